// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard and its fence sequencer.
// The WAW check is enabled at build time with HAZARD_WAW_CHECK_EN.
package hazard_scoreboard_pkg;

  localparam int MAX_OUT_DEFAULT = 4;
  localparam int NUM_REGS        = 32;
  localparam int REG_AW          = 5;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } hazard_state_type;

  typedef struct packed {
    logic              valid;
    logic              rden1;
    logic              rden2;
    logic [REG_AW-1:0] raddr1;
    logic [REG_AW-1:0] raddr2;
    logic              wren;
    logic [REG_AW-1:0] waddr;
    logic              long_op;
    logic              fence;
  } hazard_dec_in_type;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] waddr;
  } hazard_wb_in_type;

  typedef struct packed {
    logic                stall;
    logic                fence_done;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    outstanding;
  } hazard_out_type;

endpackage

// File: rtl/hazard_scoreboard_fence_fsm.sv
// FENCE sequencer: holds a fence in DRAIN until all long-latency ops retire,
// then pulses fence_done the cycle after the fence issues.
module hazard_fence_fsm
  import hazard_scoreboard_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dec_valid,
  input  logic             i_dec_fence,
  input  logic             i_flush,
  input  logic             i_out_zero,
  output hazard_state_type o_state,
  output logic             o_fence_done
);

  hazard_state_type r_state;
  hazard_state_type w_state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    o_fence_done = 1'b0;
    unique case (r_state)
      RUN: begin
        if (i_dec_valid && i_dec_fence && !i_flush)
          w_state_next = i_out_zero ? DONE : DRAIN;
      end
      DRAIN: begin
        if (i_flush)         w_state_next = RUN;
        else if (i_out_zero) w_state_next = DONE;
      end
      DONE: begin
        o_fence_done = 1'b1;
        w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight long-latency destinations; stalls decode on RAW/WAW,
// a full tracker, or a pending FENCE. WAW checking is built in with HAZARD_WAW_CHECK_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_dec_valid,
  input  logic                i_dec_rden1,
  input  logic                i_dec_rden2,
  input  logic [REG_AW-1:0]   i_dec_raddr1,
  input  logic [REG_AW-1:0]   i_dec_raddr2,
  input  logic                i_dec_wren,
  input  logic [REG_AW-1:0]   i_dec_waddr,
  input  logic                i_dec_long,
  input  logic                i_dec_fence,
  input  logic                i_wb_valid,
  input  logic [REG_AW-1:0]   i_wb_waddr,
  input  logic                i_flush,
  output logic                o_stall,
  output logic                o_fence_done,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [CNT_W-1:0]    o_outstanding
);

  hazard_dec_in_type   w_dec;
  hazard_wb_in_type    w_wb;
  hazard_out_type      w_out;
  hazard_state_type    w_state;

  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_outstanding;

  logic [NUM_REGS-1:0] w_wb_clr;
  logic [NUM_REGS-1:0] w_eff_busy;
  logic [NUM_REGS-1:0] w_busy_set;
  logic                w_raw, w_waw, w_full, w_fwait, w_drain_hold;
  logic                w_out_zero, w_issue, w_long_issue, w_wb_retire;
  logic                w_stall, w_fence_done;

  assign w_dec = '{valid: i_dec_valid, rden1: i_dec_rden1, rden2: i_dec_rden2,
                   raddr1: i_dec_raddr1, raddr2: i_dec_raddr2, wren: i_dec_wren,
                   waddr: i_dec_waddr, long_op: i_dec_long, fence: i_dec_fence};
  assign w_wb  = '{valid: i_wb_valid, waddr: i_wb_waddr};

  // A writeback landing this cycle frees its register for the instruction in decode.
  assign w_wb_clr   = w_wb.valid ? (NUM_REGS'(1) << w_wb.waddr) : '0;
  assign w_eff_busy = r_busy & ~w_wb_clr;
  assign w_out_zero = (r_outstanding == '0);

  assign w_raw = (w_dec.rden1 & w_eff_busy[w_dec.raddr1]) |
                 (w_dec.rden2 & w_eff_busy[w_dec.raddr2]);
`ifdef HAZARD_WAW_CHECK_EN
  assign w_waw = w_dec.wren & (w_dec.waddr != '0) & w_eff_busy[w_dec.waddr];
`else
  assign w_waw = 1'b0;
`endif
  // Full uses the registered count, so a same-cycle writeback does not release it.
  assign w_full       = w_dec.long_op & w_dec.wren & (r_outstanding == CNT_W'(MAX_OUT));
  assign w_fwait      = w_dec.fence & ~w_out_zero;
  assign w_drain_hold = (w_state == DRAIN) & ~w_out_zero;
  assign w_stall      = w_dec.valid & (w_raw | w_waw | w_full | w_fwait | w_drain_hold);

  assign w_issue      = w_dec.valid & ~w_stall & ~i_flush;
  assign w_long_issue = w_issue & w_dec.long_op & w_dec.wren;
  assign w_busy_set   = (w_long_issue && (w_dec.waddr != '0))
                        ? (NUM_REGS'(1) << w_dec.waddr) : '0;
  // Only a writeback to a tracked register retires an op; stray ones are ignored.
  assign w_wb_retire  = w_wb.valid & r_busy[w_wb.waddr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy        <= '0;
      r_outstanding <= '0;
    end else begin
      r_busy        <= (r_busy & ~w_wb_clr) | w_busy_set;
      r_outstanding <= r_outstanding + CNT_W'(w_long_issue) - CNT_W'(w_wb_retire);
    end
  end

  hazard_fence_fsm u_fence_fsm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dec_valid  (w_dec.valid),
    .i_dec_fence  (w_dec.fence),
    .i_flush      (i_flush),
    .i_out_zero   (w_out_zero),
    .o_state      (w_state),
    .o_fence_done (w_fence_done)
  );

  assign w_out = '{stall: w_stall, fence_done: w_fence_done,
                   busy: r_busy, outstanding: r_outstanding};

  assign o_stall       = w_out.stall;
  assign o_fence_done  = w_out.fence_done;
  assign o_busy        = w_out.busy;
  assign o_outstanding = w_out.outstanding;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use bypass, x0, full tracker,
// FENCE drain/flush, WAW (expectation follows HAZARD_WAW_CHECK_EN) and reset.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_rden1, dec_rden2, dec_wren, dec_long, dec_fence;
  logic [4:0]  dec_raddr1, dec_raddr2, dec_waddr;
  logic        wb_valid;
  logic [4:0]  wb_waddr;
  logic        flush;
  logic        stall, fence_done;
  logic [31:0] busy;
  logic [3:0]  outstanding;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.MAX_OUT(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_dec_valid   (dec_valid),
    .i_dec_rden1   (dec_rden1),
    .i_dec_rden2   (dec_rden2),
    .i_dec_raddr1  (dec_raddr1),
    .i_dec_raddr2  (dec_raddr2),
    .i_dec_wren    (dec_wren),
    .i_dec_waddr   (dec_waddr),
    .i_dec_long    (dec_long),
    .i_dec_fence   (dec_fence),
    .i_wb_valid    (wb_valid),
    .i_wb_waddr    (wb_waddr),
    .i_flush       (flush),
    .o_stall       (stall),
    .o_fence_done  (fence_done),
    .o_busy        (busy),
    .o_outstanding (outstanding)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_rden1 = 0; dec_rden2 = 0; dec_wren = 0; dec_long = 0; dec_fence = 0;
    dec_raddr1 = 0; dec_raddr2 = 0; dec_waddr = 0; wb_valid = 0; wb_waddr = 0; flush = 0;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic long_op(input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_long = 1; dec_wren = 1; dec_waddr = rd;
  endtask

  task automatic read1(input logic [4:0] rs);
    idle();
    dec_valid = 1; dec_rden1 = 1; dec_raddr1 = rs;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1; wb_waddr = rd;
  endtask

  task automatic fence();
    idle();
    dec_valid = 1; dec_fence = 1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("reset_busy", busy, 32'h0);
    check("reset_outstanding", {28'h0, outstanding}, 32'd0);
    check("reset_fence_done", {31'h0, fence_done}, 32'd0);

    // Load-use: load x5, read x5, writeback x5 two cycles later.
    long_op(5'd5); settle();
    check("ld_issue_stall", {31'h0, stall}, 32'd0);
    tick();
    check("ld_busy5", busy, 32'h20);
    check("ld_out1", {28'h0, outstanding}, 32'd1);
    read1(5'd5); settle();
    check("use_stall_c1", {31'h0, stall}, 32'd1);
    tick(); settle();
    check("use_stall_c2", {31'h0, stall}, 32'd1);
    tick();
    wb(5'd5); settle();
    check("use_bypass_c3", {31'h0, stall}, 32'd0);
    tick();
    idle();
    check("wb_busy_clear", busy, 32'h0);
    check("wb_out0", {28'h0, outstanding}, 32'd0);

    // Long op to x0: counted but never busy, never stalls.
    long_op(5'd0); tick();
    check("x0_busy", busy, 32'h0);
    check("x0_out1", {28'h0, outstanding}, 32'd1);
    read1(5'd0); settle();
    check("x0_read_stall", {31'h0, stall}, 32'd0);
    tick();
    idle(); rst = 1; tick(); rst = 0;
    check("rst_out0", {28'h0, outstanding}, 32'd0);

    // Full tracker: x1..x4 in flight, fifth long op to x6.
    for (int r = 1; r <= 4; r++) begin
      long_op(5'(r)); tick();
    end
    check("full_out4", {28'h0, outstanding}, 32'd4);
    check("full_busy", busy, 32'h1E);
    long_op(5'd6); settle();
    check("full_stall", {31'h0, stall}, 32'd1);
    wb(5'd1); settle();
    check("full_stall_same_wb", {31'h0, stall}, 32'd1);
    tick();
    check("full_out3", {28'h0, outstanding}, 32'd3);
    long_op(5'd6); settle();
    check("full_released", {31'h0, stall}, 32'd0);
    tick();
    check("full_out4_again", {28'h0, outstanding}, 32'd4);
    check("full_busy2", busy, 32'h5C);
    idle(); wb(5'd2); tick();
    idle(); wb(5'd3); tick();
    check("pre_fence_out2", {28'h0, outstanding}, 32'd2);

    // FENCE drain with two ops outstanding (x4, x6).
    fence(); settle();
    check("fence_wait_stall", {31'h0, stall}, 32'd1);
    tick();
    fence(); wb(5'd4); settle();
    check("drain_stall_a", {31'h0, stall}, 32'd1);
    tick();
    fence(); wb(5'd6); settle();
    check("drain_stall_b", {31'h0, stall}, 32'd1);
    tick();
    fence(); settle();
    check("drain_out0", {28'h0, outstanding}, 32'd0);
    check("fence_issue_stall", {31'h0, stall}, 32'd0);
    check("fence_done_early", {31'h0, fence_done}, 32'd0);
    tick();
    idle();
    check("fence_done_pulse", {31'h0, fence_done}, 32'd1);
    tick();
    check("fence_done_low", {31'h0, fence_done}, 32'd0);

    // FENCE flushed while draining returns to RUN without fence_done.
    long_op(5'd8); tick();
    fence(); tick();
    fence(); flush = 1; settle();
    check("drain_flush_stall", {31'h0, stall}, 32'd1);
    tick();
    idle();
    check("flush_no_done", {31'h0, fence_done}, 32'd0);
    check("flush_busy", busy, 32'h100);
    check("flush_out1", {28'h0, outstanding}, 32'd1);
    read1(5'd1); settle();
    check("flush_back_run", {31'h0, stall}, 32'd0);
    tick();
    check("flush_no_done2", {31'h0, fence_done}, 32'd0);
    idle(); wb(5'd8); tick();
    idle();
    check("flush_drained", {28'h0, outstanding}, 32'd0);

    // WAW: ALU write to x7 while a long op to x7 is pending, then reset mid-stall.
    long_op(5'd7); tick();
    idle(); dec_valid = 1; dec_wren = 1; dec_waddr = 5'd7; settle();
`ifdef HAZARD_WAW_CHECK_EN
    check("waw_stall", {31'h0, stall}, 32'd1);
`else
    check("waw_stall", {31'h0, stall}, 32'd0);
`endif
    rst = 1; tick(); rst = 0; settle();
    check("midstall_rst_busy", busy, 32'h0);
    check("midstall_rst_out", {28'h0, outstanding}, 32'd0);
    check("post_rst_stall", {31'h0, stall}, 32'd0);
    idle(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Tracks destination registers of in-flight long-latency instructions (loads, multiply/divide) and stalls decode on read-after-write and write-after-write hazards that the single-cycle forwarding path cannot cover. Also sequences FENCE by draining all outstanding long-latency ops before the fence issues. Sits beside the decode-stage forwarding unit; its `stall` output freezes the fetch/decode registers.

## Interface
- MAX_OUT, 4, maximum outstanding long-latency ops (1..15)
- reset  in  1  synchronous, active-high
- clock  in  1  rising-edge clock
- dec_valid  in  1  decode holds a valid instruction
- dec_rden1 / dec_rden2  in  1  source 1 / 2 read enable
- dec_raddr1 / dec_raddr2  in  5  source 1 / 2 register index
- dec_wren  in  1  instruction writes rd
- dec_waddr  in  5  rd index
- dec_long  in  1  instruction is long-latency (result arrives via writeback port)
- dec_fence  in  1  instruction is FENCE
- wb_valid  in  1  long-latency result written back this cycle
- wb_waddr  in  5  writeback rd index
- flush  in  1  squash decode instruction this cycle
- stall  out  1  hold decode (combinational)
- fence_done  out  1  one-cycle pulse, cycle after fence issues
- busy  out  32  registered busy vector; bit 0 always 0
- outstanding  out  4  registered count of in-flight long-latency ops

## Operation
- issue = dec_valid & !stall & !flush.
- wb_clr[r] = wb_valid & wb_waddr==r; eff_busy = busy & ~wb_clr (same-cycle writeback bypass).
- raw = (dec_rden1 & eff_busy[raddr1]) | (dec_rden2 & eff_busy[raddr2]).
- full = dec_long & dec_wren & outstanding==MAX_OUT.
- fwait = dec_fence & outstanding!=0.
- stall = dec_valid & (raw | waw | full | fwait | state==DRAIN & outstanding!=0).
- Busy update: clear wb_waddr if wb_valid; then set dec_waddr if issue & dec_long & dec_wren & dec_waddr!=0 (set wins over clear on same index).
- Counter: next = outstanding + (long issue) − (wb_valid & busy[wb_waddr]). Writeback to a non-busy register: ignored, no decrement, no underflow.
- Register x0 never marked busy, never causes stall.
- flush: suppresses issue; does not clear busy bits (in-flight ops still write back).
- FSM states RUN, DRAIN, DONE:
  - RUN: dec_valid & dec_fence & !flush: outstanding==0 → DONE (fence issues now); else → DRAIN.
  - DRAIN: flush → RUN; outstanding==0 → fence issues (stall low) → DONE.
  - DONE: fence_done=1; → RUN unconditionally.

## Timing
- stall: combinational, same cycle as decode inputs.
- busy/outstanding update visible one cycle after issue/writeback.
- Reset (any cycle, including mid-DRAIN): busy=0, outstanding=0, state=RUN, fence_done=0, stall follows inputs with cleared state.
- Minimum load-use stall with writeback N cycles after issue: N−1 cycles; dependent issues in writeback cycle via bypass.
- Full: the (MAX_OUT+1)th long op stalls until a writeback decrements the count; with same-cycle writeback it still stalls (registered count).

## Configuration
- HAZARD_WAW_CHECK_EN defined: waw = dec_wren & dec_waddr!=0 & eff_busy[dec_waddr]; any instruction writing a busy rd stalls.
- Undefined: waw = 0; writeback ordering guaranteed by the pipeline; a new long op to a busy rd re-sets the bit and counts separately.

## Structure
- Shared package: hazard_state_type enum (RUN, DRAIN, DONE), hazard_dec_in_type / hazard_wb_in_type / hazard_out_type structs, MAX_OUT default constant.
- One sub-module natural: hazard_fence_fsm (RUN/DRAIN/DONE and fence_done), scoreboard vector and counter in top.

## Test plan
- Load x5 issue, x5 read next cycle, wb x5 at cycle 3 → stall high cycles 1–2, low cycle 3 (bypass), busy[5]=0 cycle 4.
- Long op writing x0, then read x0 → busy stays 0, no stall, outstanding increments to 1.
- Four long ops (x1..x4), fifth long op to x6 → stall until first wb; outstanding 4→3, then fifth issues, back to 4.
- FENCE with outstanding=2 → DRAIN, stall until both wb; fence issues when outstanding=0; fence_done pulses exactly one cycle later.
- FENCE in DRAIN with flush asserted → state RUN, no fence_done, busy unchanged.
- WAW build: long to x7 pending, ALU write to x7 → stall until wb x7; non-WAW build → no stall; reset asserted mid-stall → busy=0, outstanding=0 next cycle.
